// File: rtl/trig_pkg.sv
// Shared trigger-sequencer definitions: state codes, latency defaults,
// and the registered pulse bundle used by the sequencer and counter stage.
package trig_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_L1 = 2'd1;
  localparam logic [1:0] ST_WAIT_L2 = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic [15:0] L1_WIN_MIN_DEF = 16'd200;
  localparam logic [15:0] L1_WIN_MAX_DEF = 16'd280;
  localparam logic [15:0] L2_TIMEOUT_DEF = 16'd4400;
  localparam logic [15:0] HOLDOFF_DEF    = 16'd16;

  // Shortest dead time that keeps downstream 13-clock stretches apart.
  localparam logic [15:0] STRETCH_LEN    = 16'd13;

  typedef struct packed {
    logic l1out;
    logic rdocmd;
    logic abortcmd;
    logic err_l1_win;
    logic err_l2_spur;
    logic err_l2_tmo;
    logic l0_lost;
  } trig_out_t;

  // HOLD leaves on the last dead clock, not one past it.
  function automatic logic [15:0] hold_last(input logic [15:0] h);
    return h - 16'd1;
  endfunction

endpackage

// File: rtl/trig_win_timer.sv
// Per-state 16-bit timer: restart, increment, saturate, window compares.
// Ports: clk_i, rst_ni, restart_i -> count_o, ge_min_o, eq_max_o, eq_tmo_o, eq_hold_o.
module trig_win_timer
  import trig_pkg::*;
#(
  parameter logic [15:0] WIN_MIN   = L1_WIN_MIN_DEF,
  parameter logic [15:0] WIN_MAX   = L1_WIN_MAX_DEF,
  parameter logic [15:0] TMO       = L2_TIMEOUT_DEF,
  parameter logic [15:0] HOLD_LAST = 16'd15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        restart_i,
  output logic [15:0] count_o,
  output logic        ge_min_o,
  output logic        eq_max_o,
  output logic        eq_tmo_o,
  output logic        eq_hold_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // The entry cycle of a state already counts as 1, so in WAIT_L1
  // the timer equals the number of clocks since the L0 strobe.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = 16'd1;
    end else if (count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign ge_min_o  = (count_q >= WIN_MIN);
  assign eq_max_o  = (count_q == WIN_MAX);
  assign eq_tmo_o  = (count_q == TMO);
  assign eq_hold_o = (count_q == HOLD_LAST);

endmodule

// File: rtl/trig_seq.sv
// Trigger sequencer: qualifies L0/L1/L2 strobes against latency windows,
// emits registered one-cycle l1out/rdo/abort commands and error pulses.
module trig_seq
  import trig_pkg::*;
#(
  parameter logic [15:0] L1_WIN_MIN = L1_WIN_MIN_DEF,
  parameter logic [15:0] L1_WIN_MAX = L1_WIN_MAX_DEF,
  parameter logic [15:0] L2_TIMEOUT = L2_TIMEOUT_DEF,
  parameter logic [15:0] HOLDOFF    = HOLDOFF_DEF
) (
  input  logic       gclk_40m,
  input  logic       reset,
  input  logic       l0,
  input  logic       l1,
  input  logic       l2a,
  input  logic       l2r,
  input  logic       trig_en,
  input  logic       busy,
  output logic       l1out_c,
  output logic       rdocmd_c,
  output logic       abortcmd_c,
  output logic       err_l1_win,
  output logic       err_l2_spur,
  output logic       err_l2_tmo,
  output logic       l0_lost,
  output logic [1:0] seq_state
);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  trig_out_t   out_q;
  trig_out_t   out_d;
  logic        restart;
  logic [15:0] tmr_cnt;
  logic        ge_min;
  logic        eq_max;
  logic        eq_tmo;
  logic        eq_hold;
  logic        l2_any;

  trig_win_timer #(
    .WIN_MIN   (L1_WIN_MIN),
    .WIN_MAX   (L1_WIN_MAX),
    .TMO       (L2_TIMEOUT),
    .HOLD_LAST (hold_last(HOLDOFF))
  ) u_tmr (
    .clk_i     (gclk_40m),
    .rst_ni    (reset),
    .restart_i (restart),
    .count_o   (tmr_cnt),
    .ge_min_o  (ge_min),
    .eq_max_o  (eq_max),
    .eq_tmo_o  (eq_tmo),
    .eq_hold_o (eq_hold)
  );

  assign l2_any = l2a | l2r;

  always_comb begin
    state_d = state_q;
    out_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (l0) begin
          // busy and trig_en only matter here.
          if (trig_en && !busy) begin
            state_d = ST_WAIT_L1;
          end else begin
            out_d.l0_lost = 1'b1;
          end
        end
        if (l1) out_d.err_l1_win = 1'b1;
        if (l2_any) out_d.err_l2_spur = 1'b1;
      end
      ST_WAIT_L1: begin
        // Timer never exceeds the window max here, so
        // ge_min alone decides an in-window L1.
        if (l1) begin
          if (ge_min) begin
            out_d.l1out = 1'b1;
            state_d     = ST_WAIT_L2;
          end else begin
            out_d.err_l1_win = 1'b1;
            state_d          = ST_IDLE;
          end
        end else if (eq_max) begin
          state_d = ST_IDLE;
        end
        if (l0) out_d.l0_lost = 1'b1;
        if (l2_any) out_d.err_l2_spur = 1'b1;
      end
      ST_WAIT_L2: begin
        // A real L2 strobe takes precedence over a
        // coincident timeout.
        if (l2a && l2r) begin
          out_d.abortcmd    = 1'b1;
          out_d.err_l2_spur = 1'b1;
          state_d           = ST_HOLD;
        end else if (l2a) begin
          out_d.rdocmd = 1'b1;
          state_d      = ST_HOLD;
        end else if (l2r) begin
          out_d.abortcmd = 1'b1;
          state_d        = ST_HOLD;
        end else if (eq_tmo) begin
          out_d.abortcmd   = 1'b1;
          out_d.err_l2_tmo = 1'b1;
          state_d          = ST_HOLD;
        end
        if (l1) out_d.err_l1_win = 1'b1;
        if (l0) out_d.l0_lost = 1'b1;
      end
      ST_HOLD: begin
        if (eq_hold) state_d = ST_IDLE;
        if (l0) out_d.l0_lost = 1'b1;
        if (l2_any) out_d.err_l2_spur = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign restart = (state_d != state_q);

  always_ff @(posedge gclk_40m or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign l1out_c     = out_q.l1out;
  assign rdocmd_c    = out_q.rdocmd;
  assign abortcmd_c  = out_q.abortcmd;
  assign err_l1_win  = out_q.err_l1_win;
  assign err_l2_spur = out_q.err_l2_spur;
  assign err_l2_tmo  = out_q.err_l2_tmo;
  assign l0_lost     = out_q.l0_lost;
  assign seq_state   = state_q;

endmodule
